egress_queue: RTL and testbench
===============================

Name: egress_queue

Overview:
- Per-output-port egress stage, sitting directly downstream of the 4-port switch core; one instance per output port.
- Buffers packets the switch routes to this port and presents them to the port's sink with a valid/ready handshake.
- Generates XOFF flow control with hysteresis back toward the switch.
- Keeps saturating packet and drop statistics.

Parameters:
- PACKET_WIDTH, 16: packet bit width. Header [3:0] is the source, [7:4] is the target, the rest is payload.
- DEPTH, 8: queue entries; must be a power of 2, at least 4.
- HI_WM, 6: occupancy at or above which XOFF asserts; must satisfy LO_WM < HI_WM <= DEPTH.
- LO_WM, 2: occupancy at or below which XOFF deasserts.
- CNT_WIDTH, 16: statistics counter width.

Ports:
- clk  in  1  Rising-edge clock; the block's only clock.
- rst  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Switch core presents a packet this cycle. No ready is returned.
- in_data  in  PACKET_WIDTH  Packet from the switch core.
- out_valid  out  1  Queue head is valid.
- out_data  out  PACKET_WIDTH  Queue head packet.
- out_ready  in  1  Sink accepts the head this cycle.
- xoff  out  1  Registered throttle request to the switch arbiter.
- occupancy  out  $clog2(DEPTH+1)  Current entry count.
- drop_pulse  out  1  Registered one-cycle pulse for each dropped packet.
- clr_stats  in  1  Synchronous clear of both statistics counters.
- pkt_count  out  CNT_WIDTH  Saturating count of packets accepted into the queue.
- drop_count  out  CNT_WIDTH  Saturating count of dropped packets.

Behaviour:
- Reset (async assert, sync-to-clk release handled upstream):
  - rd_ptr = wr_ptr = 0; occupancy = 0.
  - out_valid = 0; out_data = 0 (memory contents don't care; head is masked while empty).
  - xoff = 0; FSM = FLOW_ON.
  - drop_pulse = 0; pkt_count = drop_count = 0.
- Definitions:
  - pop = out_valid & out_ready.
  - full = (occupancy == DEPTH).
  - push = in_valid & (!full | pop). A push into a full queue is allowed when a pop happens in the same cycle.
  - drop = in_valid & full & !pop.
- Queue is show-ahead:
  - out_valid = (occupancy != 0); out_data = mem[rd_ptr], or 0 when empty.
  - Latency: a packet pushed at edge N is visible on out_valid/out_data after edge N; first pop is possible in cycle N+1.
  - No bypass when empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- occupancy update per edge:
  - +1 on push only; -1 on pop only; unchanged when both or neither.
  - Never exceeds DEPTH; never underflows. pop while empty is impossible because out_valid = 0.
- Ordering: strict FIFO. out_data must hold stable while out_valid=1 and out_ready=0.
- Drop:
  - Packet is discarded; no pointer or occupancy change.
  - drop_pulse = 1 on the following cycle.
  - drop_count increments, saturating at 2^CNT_WIDTH-1.
- pkt_count increments on every push, saturating at 2^CNT_WIDTH-1.
- clr_stats: both counters go to 0 on the next edge. Clear wins over a same-cycle increment. drop_pulse is unaffected.
- Flow-control FSM, evaluated on the next-state occupancy so xoff tracks occupancy with no extra lag:
  - FLOW_ON -> FLOW_OFF when next_occ >= HI_WM.
  - FLOW_OFF -> FLOW_ON when next_occ <= LO_WM.
  - Otherwise hold state.
  - xoff = 1 exactly while in FLOW_OFF.
- Reset mid-operation: all state returns to reset values immediately. In-flight packets are lost and are not counted as drops.
- The switch core is expected to honour xoff. If it does not, packets arriving at full are dropped and counted, never corrupt stored data.

Test Plan:
1. Reset check: hold rst for 3 cycles with in_valid=1 -> out_valid=0, occupancy=0, xoff=0, pkt_count=0, drop_count=0; after release nothing is stored.
2. Fill and drain ordering: out_ready=0, push 0x0011..0x0088 on 8 consecutive cycles -> occupancy=8. Then out_ready=1 -> out_data reads 0x0011..0x0088 in order over 8 cycles, pointers wrap, occupancy returns to 0.
3. Overflow drop: queue full, out_ready=0, push 0x00AA for 3 cycles -> 3 drop_pulse cycles, drop_count=3, pkt_count=8, head still 0x0011.
4. Simultaneous push/pop at full: occupancy=8, in_valid=1 with out_ready=1 -> no drop, occupancy stays 8, new packet lands at the tail.
5. XOFF hysteresis (HI_WM=6, LO_WM=2): push to 6 -> xoff=1 on the same edge occupancy reaches 6; drain to 3 -> xoff stays 1; drain to 2 -> xoff=0.
6. Counter saturation and clear (CNT_WIDTH=4): 20 accepted pushes -> pkt_count=15. Assert clr_stats in the same cycle as a push -> pkt_count=0.

Source files
------------

// File: rtl/egress_queue.sv
// Per-output-port egress queue: show-ahead FIFO with drop-on-full, XOFF hysteresis
// and saturating packet/drop statistics.
module egress_queue #(
    parameter int unsigned PACKET_WIDTH = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned HI_WM        = 6,
    parameter int unsigned LO_WM        = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PACKET_WIDTH-1:0]    in_data,
    output logic                       out_valid,
    output logic [PACKET_WIDTH-1:0]    out_data,
    input  logic                       out_ready,
    output logic                       xoff,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       drop_pulse,
    input  logic                       clr_stats,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic [CNT_WIDTH-1:0]       drop_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {FlowOn, FlowOff} flow_state_e;

    logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0]         occ_q, occ_d;
    flow_state_e             state_q, state_d;
    logic                    drop_pulse_q;
    logic [CNT_WIDTH-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

    logic pop, push, drop, full;

    assign out_valid = (occ_q != '0);
    // Head is masked while empty so stale memory never leaks out.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign full      = (occ_q == OccW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;

    assign xoff       = (state_q == FlowOff);
    assign occupancy  = occ_q;
    assign drop_pulse = drop_pulse_q;
    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !pop)      occ_d = occ_q + 1'b1;
        else if (pop && !push) occ_d = occ_q - 1'b1;
        if (clr_stats) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (push && pkt_cnt_q != '1)  pkt_cnt_d  = pkt_cnt_q + 1'b1;
            if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Watermarks are judged on next-state occupancy so xoff has no extra cycle of lag.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FlowOn:  if (occ_d >= OccW'(HI_WM)) state_d = FlowOff;
            FlowOff: if (occ_d <= OccW'(LO_WM)) state_d = FlowOn;
            default: state_d = FlowOn;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            state_q      <= FlowOn;
            drop_pulse_q <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            drop_pulse_q <= drop;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_egress_queue.sv
// Directed bench for egress_queue: vector table for fill/drop/hysteresis/clear,
// hand sequences for reset, counter saturation and mid-operation reset.
module tb_egress_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        xoff;
    logic [3:0]  occupancy;
    logic        drop_pulse;
    logic        clr_stats = 1'b0;
    logic [3:0]  pkt_count;
    logic [3:0]  drop_count;

    int checks = 0;
    int errors = 0;

    egress_queue #(
        .PACKET_WIDTH(16),
        .DEPTH       (8),
        .HI_WM       (6),
        .LO_WM       (2),
        .CNT_WIDTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .xoff      (xoff),
        .occupancy (occupancy),
        .drop_pulse(drop_pulse),
        .clr_stats (clr_stats),
        .pkt_count (pkt_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eocc;
        logic        ex;
        logic        edp;
        logic [3:0]  epkt;
        logic [3:0]  edrop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [15:0] id, input logic rdy, input logic clr,
                       input logic ev, input logic [15:0] ed, input int eocc, input logic ex,
                       input logic edp, input int epkt, input int edrop);
        vec_t v;
        v.iv = iv; v.id = id; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eocc = 4'(eocc); v.ex = ex;
        v.edp = edp; v.epkt = 4'(epkt); v.edrop = 4'(edrop);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] id, input logic rdy,
                         input logic clr);
        in_valid  = iv;
        in_data   = id;
        out_ready = rdy;
        clr_stats = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [15:0] ed,
                           input logic [3:0] eocc, input logic ex, input logic edp,
                           input logic [3:0] epkt, input logic [3:0] edrop);
        chk({tag, ".out_valid"},  32'(out_valid),  32'(ev));
        chk({tag, ".out_data"},   32'(out_data),   32'(ed));
        chk({tag, ".occupancy"},  32'(occupancy),  32'(eocc));
        chk({tag, ".xoff"},       32'(xoff),       32'(ex));
        chk({tag, ".drop_pulse"}, 32'(drop_pulse), 32'(edp));
        chk({tag, ".pkt_count"},  32'(pkt_count),  32'(epkt));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(edrop));
    endtask

    initial begin
        logic [15:0] heads [8] = '{16'h0033, 16'h0044, 16'h0055, 16'h0066,
                                   16'h0077, 16'h0088, 16'h0099, 16'h0000};
        logic [15:0] a_heads [4] = '{16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};

        // Fill with 0x0011..0x0088, sink stalled; xoff rises on the edge reaching 6.
        for (int k = 1; k <= 8; k++)
            add(1, 16'(k * 'h11), 0, 0, 1, 16'h0011, k, k >= 6, 0, k, 0);
        // Three arrivals at full are dropped; head untouched.
        for (int d = 1; d <= 3; d++)
            add(1, 16'h00AA, 0, 0, 1, 16'h0011, 8, 1, 1, 8, d);
        add(0, 16'h0000, 0, 0, 1, 16'h0011, 8, 1, 0, 8, 3);
        // Push with pop at full: no drop, 0x0099 joins the tail.
        add(1, 16'h0099, 1, 0, 1, 16'h0022, 8, 1, 0, 9, 3);
        // Drain in order; xoff holds through 3, clears at 2; pointers wrap.
        for (int p = 0; p < 8; p++)
            add(0, 16'h0000, 1, 0, p < 7, heads[p], 7 - p, p < 5, 0, 9, 3);
        // Hysteresis: up to 6, back down to 2.
        for (int j = 1; j <= 6; j++)
            add(1, 16'(16'h00A0 + j), 0, 0, 1, 16'h00A1, j, j >= 6, 0, 9 + j, 3);
        for (int j = 0; j < 4; j++)
            add(0, 16'h0000, 1, 0, 1, a_heads[j], 5 - j, j < 3, 0, 15, 3);
        // pkt_count already saturated; then clear wins over a same-cycle push.
        add(1, 16'h00B1, 0, 0, 1, 16'h00A5, 3, 0, 0, 15, 3);
        add(1, 16'h00B2, 0, 1, 1, 16'h00A5, 4, 0, 0, 0, 0);

        // Reset held 3 cycles with traffic offered.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("reset%0d", c), 0, 16'h0000, 0, 0, 0, 0, 0);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        drive(0, 16'h0000, 0, 0);
        chk_all("post_reset", 0, 16'h0000, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].rdy, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eocc, vecs[i].ex,
                    vecs[i].edp, vecs[i].epkt, vecs[i].edrop);
        end

        // Queue holds A5,A6,B1,B2; 20 push+pop cycles saturate pkt_count.
        for (int i = 0; i < 20; i++) drive(1, 16'(16'h0C00 + i), 1, 0);
        chk_all("sat_pkt", 1, 16'h0C10, 4, 0, 0, 15, 0);

        for (int i = 0; i < 4; i++) drive(1, 16'(16'h0D00 + i), 0, 0);
        chk_all("refill", 1, 16'h0C10, 8, 1, 0, 15, 0);
        for (int i = 0; i < 16; i++) drive(1, 16'h0EEE, 0, 0);
        chk_all("sat_drop", 1, 16'h0C10, 8, 1, 1, 15, 15);

        // Clear with a same-cycle drop: counters zero, drop_pulse still fires.
        drive(1, 16'h0EEE, 0, 1);
        chk_all("clr_drop", 1, 16'h0C10, 8, 1, 1, 0, 0);

        // Asynchronous reset mid-operation, observed before any clock edge.
        in_valid  = 1'b0;
        clr_stats = 1'b0;
        drive(1, 16'h0EEE, 0, 0);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 16'h0000, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
